// File: rtl/bounce_generator.sv
// bounce_generator
//   Switch-bounce emulator. A clean level command is turned into a bouncy
//   `sw` waveform: inside a window of BOUNCE_US ticks, `sw` toggles after
//   pseudo-random segment widths (MIN_W .. MIN_W+2^W_BITS-1 ticks). The
//   window is followed by a quiet SETTLE_US-tick hold at the target level,
//   and then a one-cycle `settled` pulse.
//
// Ports
//   clk        in   system clock
//   reset      in   asynchronous active-low reset
//   cmd_level  in   requested final switch level
//   cmd_valid  in   command request (taken when cmd_ready is high)
//   cmd_ready  out  high only while idle
//   sw         out  emulated bouncy switch (registered)
//   busy       out  high while bouncing or settling
//   settled    out  one-cycle pulse when a command completes
//   bounce_cnt out  glitch toggles in the last level-change command
module bounce_generator #(
    parameter int          TICK_DIV  = 100,
    parameter int          BOUNCE_US = 2000,
    parameter int          SETTLE_US = 1000,
    parameter int          MIN_W     = 20,
    parameter int          W_BITS    = 8,
    parameter logic [15:0] SEED      = 16'hACE1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_level,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    output logic       sw,
    output logic       busy,
    output logic       settled,
    output logic [7:0] bounce_cnt
);

    localparam int          PW       = $clog2(TICK_DIV);
    localparam int          WINW     = (BOUNCE_US < 1) ? 1 : $clog2(BOUNCE_US + 1);
    localparam int          SETW     = (SETTLE_US < 1) ? 1 : $clog2(SETTLE_US + 1);
    localparam int          WIDW     = $clog2(MIN_W + 2**W_BITS);
    // An all-zero LFSR would lock up, so a zero seed is remapped.
    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;

    typedef enum logic [1:0] {IDLE, BOUNCE, SETTLE} state_t;

    state_t            state_q, state_d;
    logic              sw_q, sw_d;
    logic              target_q, target_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [15:0]       lfsr_q, lfsr_d;
    logic [PW-1:0]     presc_q, presc_d;
    logic              tick_q, tick_d;
    logic [WINW-1:0]   win_q, win_d;
    logic [WIDW-1:0]   wid_q, wid_d;
    logic [SETW-1:0]   set_q, set_d;
    logic              settled_q, settled_d;
    logic              busy_q, busy_d;
    logic              ready_q, ready_d;

    logic [15:0]       lfsr_nxt;
    logic [WIDW-1:0]   wid_load;
    logic [WINW-1:0]   win_dec;
    logic [WIDW-1:0]   wid_dec;
    logic [SETW-1:0]   set_dec;

    always_comb begin
        // Fibonacci taps 16,14,13,11; shift left, feedback into bit 0.
        lfsr_nxt = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        wid_load = WIDW'(MIN_W) + WIDW'(lfsr_q[W_BITS-1:0]);
        win_dec  = win_q - WINW'(1);
        wid_dec  = wid_q - WIDW'(1);
        set_dec  = set_q - SETW'(1);

        state_d   = state_q;
        sw_d      = sw_q;
        target_d  = target_q;
        cnt_d     = cnt_q;
        lfsr_d    = lfsr_q;
        win_d     = win_q;
        wid_d     = wid_q;
        set_d     = set_q;
        settled_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    target_d = cmd_level;
                    if (cmd_level == sw_q) begin
                        settled_d = 1'b1;
                    end else begin
                        sw_d    = cmd_level;
                        cnt_d   = 8'd0;
                        state_d = BOUNCE;
                        win_d   = WINW'(BOUNCE_US);
                        wid_d   = wid_load;
                        lfsr_d  = lfsr_nxt;
                    end
                end
            end
            BOUNCE: begin
                if (tick_q) begin
                    win_d = win_dec;
                    wid_d = wid_dec;
                    // Window end takes priority over a coincident width expiry.
                    if (win_dec == '0) begin
                        sw_d    = target_q;
                        state_d = SETTLE;
                        set_d   = SETW'(SETTLE_US);
                    end else if (wid_dec == '0) begin
                        sw_d   = ~sw_q;
                        cnt_d  = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
                        wid_d  = wid_load;
                        lfsr_d = lfsr_nxt;
                    end
                end
            end
            SETTLE: begin
                if (tick_q) begin
                    set_d = set_dec;
                    if (set_dec == '0) begin
                        state_d   = IDLE;
                        settled_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Prescaler runs only while busy and is held clear in IDLE, so the
        // first tick lands a fixed TICK_DIV+1 clocks after the accepting edge.
        if (state_q == IDLE) begin
            presc_d = '0;
            tick_d  = 1'b0;
        end else begin
            tick_d  = (presc_q == PW'(TICK_DIV - 1));
            presc_d = tick_d ? '0 : presc_q + PW'(1);
        end

        busy_d  = (state_d != IDLE);
        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            sw_q      <= 1'b0;
            target_q  <= 1'b0;
            cnt_q     <= 8'd0;
            lfsr_q    <= SEED_EFF;
            presc_q   <= '0;
            tick_q    <= 1'b0;
            win_q     <= '0;
            wid_q     <= '0;
            set_q     <= '0;
            settled_q <= 1'b0;
            busy_q    <= 1'b0;
            ready_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            sw_q      <= sw_d;
            target_q  <= target_d;
            cnt_q     <= cnt_d;
            lfsr_q    <= lfsr_d;
            presc_q   <= presc_d;
            tick_q    <= tick_d;
            win_q     <= win_d;
            wid_q     <= wid_d;
            set_q     <= set_d;
            settled_q <= settled_d;
            busy_q    <= busy_d;
            ready_q   <= ready_d;
        end
    end

    assign sw         = sw_q;
    assign busy       = busy_q;
    assign cmd_ready  = ready_q;
    assign settled    = settled_q;
    assign bounce_cnt = cnt_q;

endmodule
